// File: rtl/max7219_pkg.sv
// ----------------------------------------------------------------------------
// max7219_pkg
//   Shared constants for the MAX7219 serial-slave model: register address
//   map, frame field geometry and the Code-B seven-segment patterns.
//   Segment patterns are 7 bits in A,B,C,D,E,F,G order (bit6..bit0); the
//   decimal point is prepended separately by the decoder.
// ----------------------------------------------------------------------------
package max7219_pkg;

    // Register address map (frame bits [11:8])
    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    localparam int NUM_DIGITS = 8;

    // Bit counter: wide enough to count a two-device daisy chain, saturating.
    localparam int         CNT_W   = 5;
    localparam logic [4:0] CNT_MAX = 5'd31;

    // Code-B segment patterns, A..G
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_DASH  = 7'h01;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_H     = 7'h37;
    localparam logic [6:0] SEG_L     = 7'h0E;
    localparam logic [6:0] SEG_P     = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/max7219_codeb_decoder.sv
// ----------------------------------------------------------------------------
// max7219_codeb_decoder
//   Combinational Code-B font: maps a 4-bit code plus decimal point to the
//   segment byte presented on the digit outputs.
//   Ports:
//     code  in  4  Code-B value (0-9, '-', E, H, L, P, blank)
//     dp    in  1  decimal point (data bit 7 of the digit register)
//     seg   out 8  segments DP,A,B,C,D,E,F,G (bit7..0)
// ----------------------------------------------------------------------------
module max7219_codeb_decoder
    import max7219_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [6:0] seg_font;

    always_comb begin
        // NOTE: default assignment first so every path drives seg_font; a
        // missing branch would otherwise infer a latch.
        seg_font = SEG_BLANK;
        case (code)
            4'h0: seg_font = SEG_0;
            4'h1: seg_font = SEG_1;
            4'h2: seg_font = SEG_2;
            4'h3: seg_font = SEG_3;
            4'h4: seg_font = SEG_4;
            4'h5: seg_font = SEG_5;
            4'h6: seg_font = SEG_6;
            4'h7: seg_font = SEG_7;
            4'h8: seg_font = SEG_8;
            4'h9: seg_font = SEG_9;
            4'hA: seg_font = SEG_DASH;
            4'hB: seg_font = SEG_E;
            4'hC: seg_font = SEG_H;
            4'hD: seg_font = SEG_L;
            4'hE: seg_font = SEG_P;
            default: seg_font = SEG_BLANK;
        endcase
    end

    assign seg = {dp, seg_font};

endmodule

// File: rtl/max7219_receiver.sv
// ----------------------------------------------------------------------------
// max7219_receiver
//   Synthesizable MAX7219 serial slave. Oversamples the 3-wire link on i_clk,
//   shifts frames in on serial-clock rising edges, commits register writes on
//   LOAD rising edges and exposes the display state in parallel. DOUT follows
//   the shift-register MSB on serial-clock falling edges for daisy chains.
//
//   Optional build macro: MAX7219_CODEB_EN
//     defined   -> digits whose decode-mode bit is set show the Code-B font
//     undefined -> o_digits carries the raw digit registers
//
//   Parameters:
//     SYNC_STAGES  synchronizer depth on serial clk/load/din (>= 2)
//     FRAME_BITS   bits per frame; [11:8] address, [7:0] data
//
//   Ports:
//     i_clk, i_reset   system clock, async active-high reset
//     i_serial_din     serial data
//     i_serial_load    LOAD/CS, rising edge commits
//     i_serial_clk     serial clock, shift on rising edge
//     o_serial_dout    daisy-chain output
//     o_digits         digit 0 at [7:0] .. digit 7 at [63:56]
//     o_intensity      intensity register
//     o_scan_limit     scan-limit register
//     o_shutdown_n     0 = shutdown
//     o_test           display-test bit
//     o_wr_stb         one-cycle pulse per committed frame
//     o_wr_addr        address of last committed frame
//     o_wr_data        data of last committed frame
//     o_frame_err      one-cycle pulse on a short frame
// ----------------------------------------------------------------------------
module max7219_receiver
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_serial_din,
    input  logic        i_serial_load,
    input  logic        i_serial_clk,
    output logic        o_serial_dout,
    output logic [63:0] o_digits,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic        o_shutdown_n,
    output logic        o_test,
    output logic        o_wr_stb,
    output logic [3:0]  o_wr_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_frame_err
);

    // ------------------------------------------------------------------
    // Input synchronizers plus one extra copy for edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync, load_sync, din_sync;
    logic                   sclk_prev, load_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sclk_sync <= '0;
            load_sync <= '0;
            din_sync  <= '0;
            sclk_prev <= 1'b0;
            load_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each flop samples the value
            // its neighbour held before this edge, giving a true pipeline.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_serial_clk};
            load_sync <= {load_sync[SYNC_STAGES-2:0], i_serial_load};
            din_sync  <= {din_sync[SYNC_STAGES-2:0],  i_serial_din};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            load_prev <= load_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, load_s, din_s;
    logic sclk_rise, sclk_fall, load_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign load_s    = load_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s &  sclk_prev;
    assign load_rise =  load_s & ~load_prev;

    // ------------------------------------------------------------------
    // Shift register and bit counter. The commit path looks at the
    // post-shift value so a serial-clock edge and a LOAD edge landing in the
    // same sampled cycle behave as "shift, then commit".
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] shift_q, shift_next;
    logic [CNT_W-1:0]      bit_cnt, cnt_next;

    always_comb begin
        shift_next = shift_q;
        cnt_next   = bit_cnt;
        if (sclk_rise) begin
            shift_next = {shift_q[FRAME_BITS-2:0], din_s};
            if (bit_cnt != CNT_MAX)
                cnt_next = bit_cnt + 1'b1;
        end
    end

    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_ok;

    // Only the last FRAME_BITS bits are held, so an over-long frame from a
    // daisy chain naturally commits its tail.
    assign frame_addr = shift_next[11:8];
    assign frame_data = shift_next[7:0];
    assign frame_ok   = int'(cnt_next) >= FRAME_BITS;

    // ------------------------------------------------------------------
    // Register file and strobes
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0][7:0] digit_q;
    logic [7:0]                 decode_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift_q       <= '0;
            bit_cnt       <= '0;
            o_serial_dout <= 1'b0;
            // NOTE: the digit registers are reset too; they are visible
            // outputs that must read zero out of reset, not scratch storage.
            digit_q       <= '0;
            decode_q      <= '0;
            o_intensity   <= '0;
            o_scan_limit  <= '0;
            o_shutdown_n  <= 1'b0;
            o_test        <= 1'b0;
            o_wr_stb      <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_frame_err   <= 1'b0;
        end else begin
            o_wr_stb    <= 1'b0;
            o_frame_err <= 1'b0;
            shift_q     <= shift_next;
            bit_cnt     <= load_rise ? '0 : cnt_next;

            // DOUT changes on the falling edge, as on the real part.
            if (sclk_fall)
                o_serial_dout <= shift_q[FRAME_BITS-1];

            if (load_rise) begin
                if (!frame_ok) begin
                    o_frame_err <= 1'b1;
                end else begin
                    o_wr_stb  <= 1'b1;
                    o_wr_addr <= frame_addr;
                    o_wr_data <= frame_data;
                    case (frame_addr)
                        ADDR_NOOP: ;
                        ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                        ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                            digit_q[3'(frame_addr - ADDR_DIGIT0)] <= frame_data;
                        ADDR_DECODE:    decode_q     <= frame_data;
                        ADDR_INTENSITY: o_intensity  <= frame_data[3:0];
                        ADDR_SCANLIM:   o_scan_limit <= frame_data[2:0];
                        ADDR_SHUTDOWN:  o_shutdown_n <= frame_data[0];
                        ADDR_TEST:      o_test       <= frame_data[0];
                        default: ;  // 0xD, 0xE: acknowledged, not stored
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit output path
    // ------------------------------------------------------------------
`ifdef MAX7219_CODEB_EN
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_codeb
        logic [7:0] seg;

        max7219_codeb_decoder u_codeb (
            .code (digit_q[g][3:0]),
            .dp   (digit_q[g][7]),
            .seg  (seg)
        );

        assign o_digits[g*8 +: 8] = decode_q[g] ? seg : digit_q[g];
    end
`else
    assign o_digits = digit_q;

    // Decode mode is stored for register-map completeness but has no effect
    // on the raw digit path.
    logic unused_decode;
    assign unused_decode = ^decode_q;
`endif

endmodule

// File: doc/max7219_receiver.md
Name: max7219_receiver

Overview:
- Synthesizable model of the MAX7219 serial slave: the far end of the display driver's 3-wire link.
- Oversamples DIN/LOAD/CLK on the system clock, shifts in 16-bit frames and commits register writes on the LOAD rising edge.
- Exposes the resulting display state as parallel outputs and passes bits through on DOUT for daisy-chaining.
- Serves as an on-chip loopback target for driver self-test and as the board-level display model in system benches.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on serial clk/load/din (minimum 2).
- FRAME_BITS, 16, bits per frame. Frame layout: [15:12] don't-care, [11:8] address, [7:0] data.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_serial_din  input  1  serial data from driver
- i_serial_load  input  1  LOAD/CS; rising edge commits the frame
- i_serial_clk  input  1  serial clock; data is shifted on its rising edge
- o_serial_dout  output  1  daisy-chain output (shift register MSB)
- o_digits  output  64  digit 0 at [7:0] through digit 7 at [63:56]; segment order DP,A,B,C,D,E,F,G (bit7..0)
- o_intensity  output  4  intensity register
- o_scan_limit  output  3  scan-limit register
- o_shutdown_n  output  1  shutdown register bit0; 0 means shutdown
- o_test  output  1  display-test register bit0
- o_wr_stb  output  1  one-cycle pulse for every committed frame, including no-op and ignored addresses
- o_wr_addr  output  4  address of the last committed frame
- o_wr_data  output  8  data of the last committed frame
- o_frame_err  output  1  one-cycle pulse when LOAD rises after fewer than FRAME_BITS clocks

Behaviour:
- Reset: clears all registers, shift register, bit counter and every output to 0. The display therefore comes up in shutdown mode (o_shutdown_n=0).
- Synchronization and edge detection:
  - Each serial input passes through SYNC_STAGES flops.
  - Edges are detected by comparing against one further registered copy.
  - Serial clk high and low phases must each last at least SYNC_STAGES+1 i_clk cycles.
- Serial clk rising edge:
  - shift <= {shift[14:0], din_sync}.
  - Bit counter increments and saturates at 31.
- Serial clk falling edge: o_serial_dout <= shift[15]. This matches the MAX7219, which changes DOUT on the falling edge.
- LOAD rising edge:
  - Decode address shift[11:8].
  - If the bit count is < FRAME_BITS, pulse o_frame_err and discard the frame: no register update and no o_wr_stb.
  - Otherwise commit and pulse o_wr_stb. If count > 16 (a daisy chain), the last 16 bits shifted in are the ones used.
  - The bit counter clears on every LOAD rising edge.
- Address map:
  - 0x0: no-op.
  - 0x1..0x8: digit 0..7 register.
  - 0x9: decode mode.
  - 0xA: intensity, data[3:0].
  - 0xB: scan limit, data[2:0].
  - 0xC: shutdown, data[0].
  - 0xD, 0xE: ignored.
  - 0xF: display test, data[0].
- Latency: register outputs and o_wr_stb update exactly SYNC_STAGES+1 i_clk cycles after the LOAD rising edge is sampled at the pin.
- Simultaneous serial clk and LOAD edges in the same sampled cycle: the shift happens first, then the commit uses the post-shift value.
- Serial clk edges while LOAD is high: still shifted. The next LOAD rising edge is required before those bits commit.
- Reset mid-frame: the partial frame is lost and all registers return to reset values.

Optional Feature:
- Macro: MAX7219_CODEB_EN.
- With it defined:
  - For each digit whose decode-mode bit is set, o_digits presents the Code-B decode of data[3:0].
  - Codes 0-9 map to digits; A='-', B='E', C='H', D='L', E='P', F=blank.
  - DP is taken from data[7].
- Without it: o_digits always carries the raw digit registers and the decode-mode register is stored but unused.

Decomposition:
- Package max7219_pkg: address localparams (ADDR_NOOP, ADDR_DIGIT0..7, ADDR_DECODE, ADDR_INTENSITY, ADDR_SCANLIM, ADDR_SHUTDOWN, ADDR_TEST) and the Code-B segment constants.
- Sub-module max7219_codeb_decoder (4+1 bits in, 8 segment bits out), instantiated 8 times under the macro.

Test Plan:
- Reset -> all outputs 0, o_shutdown_n=0. Then frame 0x0C01 -> o_shutdown_n=1 and exactly one o_wr_stb with o_wr_addr=0xC, o_wr_data=0x01.
- Frames 0x0A07 and 0x0B05 -> o_intensity=0x7, o_scan_limit=0x5. Frame 0x0D55 -> o_wr_stb pulses but no register changes.
- Decode 0x09FF, then frames 0x0205 and 0x0385 -> o_digits[15:8]=0x5B, [23:16]=0xDB with CODEB_EN. Without the macro -> 0x05 and 0x85.
- 12 serial clocks then LOAD -> o_frame_err pulses once, no o_wr_stb, registers unchanged.
- 32-bit frame 0x0101_0603 -> commit addr 6 data 0x03, and o_serial_dout reproduces the first 16 bits delayed by 16 serial clocks.
- Reset asserted after 8 bits, then a full frame 0x0142 -> only 0x42 in digit 0 and no o_frame_err.
